alu_sequencer: RTL

- Multi-cycle control unit for the 8-bit MCU datapath.
- Fetches 16-bit instructions over a req/ack instruction-memory handshake and decodes them.
- Drives the ALU function select (fs), shift amount (sh), B-operand mux select and register-file addresses and write enable.
- Resolves branches and jumps from the ALU Zero output, handles the blocking IN-port handshake, and holds the architectural PC and N/Z/C/V flags.

---
 rtl/mcu_pkg.sv | 52 +++++
 rtl/alu_sequencer_if.sv | 34 +++
 rtl/alu_seq_decode.sv | 69 ++++++
 rtl/alu_sequencer.sv | 123 ++++++++++++
 4 files changed

// File: rtl/mcu_pkg.sv
// mcu_pkg: shared definitions for the 8-bit MCU control path.
//   - opcode encodings (ir[15:12])
//   - ALU function-select encodings that differ from the opcode
//   - sequencer FSM state encoding
//   - B-operand mux select encodings
//   - instruction field bit positions
package mcu_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_PASSB = 4'h2;
  localparam logic [3:0] OP_SLT   = 4'h3;
  localparam logic [3:0] OP_AND   = 4'h4;
  localparam logic [3:0] OP_LD    = 4'h5;
  localparam logic [3:0] OP_SUB   = 4'h6;
  localparam logic [3:0] OP_SLL   = 4'h7;
  localparam logic [3:0] OP_IN    = 4'h8;
  localparam logic [3:0] OP_XORI  = 4'h9;
  localparam logic [3:0] OP_ADDI  = 4'hA;
  localparam logic [3:0] OP_BZ    = 4'hB;
  localparam logic [3:0] OP_BNZ   = 4'hC;
  localparam logic [3:0] OP_ST    = 4'hD;
  localparam logic [3:0] OP_MOV   = 4'hE;
  localparam logic [3:0] OP_JMP   = 4'hF;

  // ALU function selects that do not simply echo the opcode.
  localparam logic [3:0] FS_ZERO  = 4'h0;
  localparam logic [3:0] FS_PASSB = 4'h2;  // F = B
  localparam logic [3:0] FS_PASSA = 4'h5;  // F = A

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WB     = 2'd3
  } state_t;

  localparam logic [1:0] BSEL_RF  = 2'd0;
  localparam logic [1:0] BSEL_IMM = 2'd1;
  localparam logic [1:0] BSEL_IN  = 2'd2;

  // Instruction field positions.
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 10;
  localparam int RB_MSB  = 9;
  localparam int RB_LSB  = 8;
  localparam int IMM_MSB = 7;
  localparam int SH_MSB  = 2;

endpackage

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: instruction-memory fetch handshake plus the IN port.
//   imem_req  : sequencer -> imem, fetch request
//   imem_addr : sequencer -> imem, fetch address
//   imem_ack  : imem -> sequencer, imem_data valid this cycle
//   imem_data : imem -> sequencer, instruction word
//   in_valid  : port -> sequencer, IN data available
//   in_ready  : sequencer -> port, IN data consumed
//
// Handshake semantics: a fetch completes on a rising edge where
// imem_req && imem_ack; imem_req stays high until then and imem_ack is
// ignored while imem_req is low. An IN transfer completes on a rising edge
// where in_valid && in_ready; in_ready is only ever high in a cycle where
// in_valid is high, so it is a one-cycle consume pulse.
interface alu_sequencer_if #(
  parameter int PC_W = 8,
  parameter int IR_W = 16
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [IR_W-1:0] imem_data;
  logic            in_valid;
  logic            in_ready;

  modport master (
    output imem_req, imem_addr, in_ready,
    input  imem_ack, imem_data, in_valid
  );

  modport slave (
    input  imem_req, imem_addr, in_ready,
    output imem_ack, imem_data, in_valid
  );
endinterface

// File: rtl/alu_seq_decode.sv
// alu_seq_decode: combinational opcode decoder.
//   op        : in,  instruction opcode ir[15:12]
//   fs        : out, ALU function select for EXEC/WB
//   b_sel     : out, B-operand mux select
//   wr_en     : out, instruction writes the register file
//   flag_en   : out, instruction updates N/Z/C/V
//   is_branch : out, BZ or BNZ
//   is_jump   : out, JMP
//   is_store  : out, ST
//   is_in     : out, IN (blocks in EXEC on the IN port)
module alu_seq_decode
  import mcu_pkg::*;
(
  input  logic [3:0] op,
  output logic [3:0] fs,
  output logic [1:0] b_sel,
  output logic       wr_en,
  output logic       flag_en,
  output logic       is_branch,
  output logic       is_jump,
  output logic       is_store,
  output logic       is_in
);

  always_comb begin
    fs        = op;
    b_sel     = BSEL_RF;
    wr_en     = 1'b0;
    flag_en   = 1'b0;
    is_branch = 1'b0;
    is_jump   = 1'b0;
    is_store  = 1'b0;
    is_in     = 1'b0;
    case (op)
      OP_NOP: fs = FS_ZERO;
      OP_ADD, OP_SLT, OP_AND, OP_SUB, OP_SLL: begin
        wr_en   = 1'b1;
        flag_en = 1'b1;
      end
      OP_PASSB, OP_LD: wr_en = 1'b1;
      OP_IN: begin
        wr_en = 1'b1;
        b_sel = BSEL_IN;
        is_in = 1'b1;
      end
      OP_XORI, OP_ADDI: begin
        wr_en   = 1'b1;
        flag_en = 1'b1;
        b_sel   = BSEL_IMM;
      end
      // Pass rf[ra] through the ALU so alu_z tests the register.
      OP_BZ, OP_BNZ: begin
        fs        = FS_PASSA;
        is_branch = 1'b1;
      end
      OP_ST: is_store = 1'b1;
      OP_MOV: begin
        fs    = FS_PASSB;
        wr_en = 1'b1;
      end
      OP_JMP: begin
        fs      = FS_ZERO;
        is_jump = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle control unit of the 8-bit MCU datapath.
// FETCH -> DECODE -> EXEC -> WB, four cycles per instruction plus stalls.
//   clk, reset     : clock, synchronous active-high reset
//   bus            : fetch handshake and IN port (alu_sequencer_if.master)
//   fs, sh         : ALU function select and shift amount
//   b_sel, imm     : B-operand mux select and immediate
//   rf_ra/rb/wa    : register-file addresses, rf_we write pulse in WB
//   st_en          : store strobe in WB of ST
//   alu_n/z/c/v    : ALU status inputs
//   flags          : architectural {N,Z,C,V}
//   pc             : program counter
//   state          : FSM state, for debug
module alu_sequencer
  import mcu_pkg::*;
#(
  parameter int PC_W = 8,
  parameter int RA_W = 2,
  parameter int IR_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  alu_sequencer_if.master  bus,
  output logic [3:0]       fs,
  output logic [2:0]       sh,
  output logic [1:0]       b_sel,
  output logic [7:0]       imm,
  output logic [RA_W-1:0]  rf_ra,
  output logic [RA_W-1:0]  rf_rb,
  output logic [RA_W-1:0]  rf_wa,
  output logic             rf_we,
  output logic             st_en,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic             alu_c,
  input  logic             alu_v,
  output logic [3:0]       flags,
  output logic [PC_W-1:0]  pc,
  output logic [1:0]       state
);

  state_t          st;
  logic [IR_W-1:0] ir;
  logic            taken;

  logic [3:0] d_fs;
  logic [1:0] d_bsel;
  logic       d_wr_en, d_flag_en, d_is_branch, d_is_jump, d_is_store, d_is_in;

  alu_seq_decode u_decode (
    .op        (ir[OP_MSB:OP_LSB]),
    .fs        (d_fs),
    .b_sel     (d_bsel),
    .wr_en     (d_wr_en),
    .flag_en   (d_flag_en),
    .is_branch (d_is_branch),
    .is_jump   (d_is_jump),
    .is_store  (d_is_store),
    .is_in     (d_is_in)
  );

  // Field outputs come straight from the registered ir, so they are stable
  // from DECODE onwards.
  assign rf_ra = ir[RD_MSB:RD_LSB];
  assign rf_wa = ir[RD_MSB:RD_LSB];
  assign rf_rb = ir[RB_MSB:RB_LSB];
  assign imm   = ir[IMM_MSB:0];
  assign sh    = ir[SH_MSB:0];
  assign state = st;

  assign bus.imem_addr = pc;
  // Masked by reset so nothing is requested or consumed in a reset cycle.
  assign bus.imem_req  = (st == ST_FETCH) && !reset;
  assign bus.in_ready  = (st == ST_EXEC) && d_is_in && bus.in_valid && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      st    <= ST_FETCH;
      pc    <= '0;
      ir    <= '0;
      flags <= 4'b0000;
      fs    <= FS_ZERO;
      b_sel <= BSEL_RF;
      rf_we <= 1'b0;
      st_en <= 1'b0;
      taken <= 1'b0;
    end else begin
      case (st)
        ST_FETCH: begin
          if (bus.imem_ack) begin
            ir <= bus.imem_data;
            st <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          fs    <= d_fs;
          b_sel <= d_bsel;
          st    <= ST_EXEC;
        end
        ST_EXEC: begin
          // BZ is opcode bit0 = 1, BNZ is bit0 = 0.
          taken <= d_is_branch && (alu_z == ir[OP_LSB]);
          if (!d_is_in || bus.in_valid) begin
            rf_we <= d_wr_en;
            st_en <= d_is_store;
            st    <= ST_WB;
          end
        end
        ST_WB: begin
          rf_we <= 1'b0;
          st_en <= 1'b0;
          fs    <= FS_ZERO;
          b_sel <= BSEL_RF;
          if (d_flag_en) flags <= {alu_n, alu_z, alu_c, alu_v};
          if (taken || d_is_jump) pc <= PC_W'(imm);
          else                    pc <= pc + PC_W'(1);
          st <= ST_FETCH;
        end
        default: st <= ST_FETCH;
      endcase
    end
  end

endmodule
